// File: rtl/chain_shift_controller.sv
// chain_shift_controller
//   Master-side driver for a daisy chain of configuration register cells.
//   A word accepted over a valid/ready handshake is serialized into the
//   first cell's chain input while the shift enable is held high. At the
//   same time, the bits that come back from the last cell are captured.
//   Those bits are the previous chain contents. After an optional settle
//   gap, an update strobe makes every cell move its shifted bit to its
//   parallel output. The captured word is then reported with a one-cycle
//   valid pulse.
//
// Ports
//   clk            : single clock; FSM on rising edge, chain outputs on falling edge
//   reset          : asynchronous active-high reset
//   data_in        : word to load into the chain
//   data_valid     : data_in valid
//   data_ready     : controller idle and able to accept a word
//   abort          : cancel a transfer while shifting or settling
//   chain_tx       : serial data to the first cell
//   enable         : shift enable to all cells
//   update         : update strobe to all cells
//   chain_rx       : serial data from the last cell
//   readback       : previous chain contents captured during the shift
//   readback_valid : one-cycle pulse, readback valid
//   busy           : transfer in progress
module chain_shift_controller #(
    parameter int CHAIN_LENGTH  = 32,
    parameter int MSB_FIRST     = 1,
    parameter int SETTLE_CYCLES = 1,
    parameter int UPDATE_CYCLES = 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [CHAIN_LENGTH-1:0] data_in,
    input  logic                    data_valid,
    output logic                    data_ready,
    input  logic                    abort,
    output logic                    chain_tx,
    output logic                    enable,
    output logic                    update,
    input  logic                    chain_rx,
    output logic [CHAIN_LENGTH-1:0] readback,
    output logic                    readback_valid,
    output logic                    busy
);

    localparam int CNT_W   = $clog2(CHAIN_LENGTH);
    localparam int CYC_MAX = (SETTLE_CYCLES > UPDATE_CYCLES) ? SETTLE_CYCLES : UPDATE_CYCLES;
    localparam int CYC_W   = $clog2(CYC_MAX + 1);
    localparam logic [CNT_W-1:0] BIT_LAST    = CNT_W'(CHAIN_LENGTH - 1);
    localparam logic [CYC_W-1:0] SETTLE_LAST = CYC_W'((SETTLE_CYCLES > 0) ? (SETTLE_CYCLES - 1) : 0);
    localparam logic [CYC_W-1:0] UPDATE_LAST = CYC_W'(UPDATE_CYCLES - 1);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SHIFT  = 3'd1,
        ST_SETTLE = 3'd2,
        ST_UPDATE = 3'd3,
        ST_DONE   = 3'd4
    } state_t;

    state_t                  state_q, state_d;
    logic [CNT_W-1:0]        bit_cnt_q, bit_cnt_d;
    logic [CYC_W-1:0]        cyc_cnt_q, cyc_cnt_d;
    logic [CHAIN_LENGTH-1:0] shreg_q, shreg_d;
    logic [CHAIN_LENGTH-1:0] capt_q;
    logic [CHAIN_LENGTH-1:0] readback_q;
    logic                    readback_valid_q;
    logic                    data_ready_q;
    logic                    busy_q;
    logic                    chain_tx_q, chain_tx_d;
    logic                    enable_q, enable_d;
    logic                    update_q, update_d;

    // Next-state logic and the rising-edge view of the chain-facing signals
    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        cyc_cnt_d  = cyc_cnt_q;
        shreg_d    = shreg_q;
        chain_tx_d = 1'b0;
        enable_d   = 1'b0;
        update_d   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (data_valid && data_ready_q) begin
                    shreg_d   = data_in;
                    bit_cnt_d = {CNT_W{1'b0}};
                    state_d   = ST_SHIFT;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                enable_d = 1'b1;
                if (MSB_FIRST != 0) begin
                    chain_tx_d = shreg_q[CHAIN_LENGTH-1];
                end else begin
                    chain_tx_d = shreg_q[0];
                end
                // abort also wins over the final shift edge
                if (abort) begin
                    state_d = ST_IDLE;
                end else begin
                    if (MSB_FIRST != 0) begin
                        shreg_d = {shreg_q[CHAIN_LENGTH-2:0], 1'b0};
                    end else begin
                        shreg_d = {1'b0, shreg_q[CHAIN_LENGTH-1:1]};
                    end
                    bit_cnt_d = bit_cnt_q + CNT_W'(1);
                    if (bit_cnt_q == BIT_LAST) begin
                        cyc_cnt_d = {CYC_W{1'b0}};
                        if (SETTLE_CYCLES == 0) begin
                            state_d = ST_UPDATE;
                        end else begin
                            state_d = ST_SETTLE;
                        end
                    end else begin
                        state_d = ST_SHIFT;
                    end
                end
            end
            ST_SETTLE: begin
                if (abort) begin
                    state_d = ST_IDLE;
                end else if (cyc_cnt_q == SETTLE_LAST) begin
                    cyc_cnt_d = {CYC_W{1'b0}};
                    state_d   = ST_UPDATE;
                end else begin
                    cyc_cnt_d = cyc_cnt_q + CYC_W'(1);
                end
            end
            ST_UPDATE: begin
                update_d = 1'b1;
                if (cyc_cnt_q == UPDATE_LAST) begin
                    state_d = ST_DONE;
                end else begin
                    cyc_cnt_d = cyc_cnt_q + CYC_W'(1);
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // FSM state, counters and the handshake/status outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q          <= ST_IDLE;
            bit_cnt_q        <= {CNT_W{1'b0}};
            cyc_cnt_q        <= {CYC_W{1'b0}};
            shreg_q          <= {CHAIN_LENGTH{1'b0}};
            readback_q       <= {CHAIN_LENGTH{1'b0}};
            readback_valid_q <= 1'b0;
            data_ready_q     <= 1'b0;
            busy_q           <= 1'b0;
        end else begin
            state_q          <= state_d;
            bit_cnt_q        <= bit_cnt_d;
            cyc_cnt_q        <= cyc_cnt_d;
            shreg_q          <= shreg_d;
            data_ready_q     <= (state_d == ST_IDLE);
            busy_q           <= (state_d != ST_IDLE);
            readback_valid_q <= (state_d == ST_DONE);
            // capture is complete well before DONE because UPDATE lasts at least one cycle
            if (state_d == ST_DONE) begin
                readback_q <= capt_q;
            end else begin
                readback_q <= readback_q;
            end
        end
    end

    // Sample the returning chain bits on every edge that the cells see enabled
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            capt_q <= {CHAIN_LENGTH{1'b0}};
        end else if (enable_q) begin
            if (MSB_FIRST != 0) begin
                capt_q <= {capt_q[CHAIN_LENGTH-2:0], chain_rx};
            end else begin
                capt_q <= {chain_rx, capt_q[CHAIN_LENGTH-1:1]};
            end
        end else begin
            capt_q <= capt_q;
        end
    end

    // Launch chain-facing signals half a cycle after the FSM to avoid hold races
    always_ff @(negedge clk or posedge reset) begin
        if (reset) begin
            chain_tx_q <= 1'b0;
            enable_q   <= 1'b0;
            update_q   <= 1'b0;
        end else begin
            chain_tx_q <= chain_tx_d;
            enable_q   <= enable_d;
            update_q   <= update_d;
        end
    end

    assign data_ready     = data_ready_q;
    assign busy           = busy_q;
    assign readback       = readback_q;
    assign readback_valid = readback_valid_q;
    assign chain_tx       = chain_tx_q;
    assign enable         = enable_q;
    assign update         = update_q;

endmodule

// File: tb/tb_chain_shift_controller.sv
// Directed bench for chain_shift_controller. Three 8-cell instances:
//   0: MSB first, settle 1, update 1
//   1: LSB first, settle 1, update 1
//   2: MSB first, settle 0, update 3
// Each instance drives a behavioural chain of cells. sh_m is the chain,
// with sh_m[7] as the last cell; par_m holds the parallel outputs.
module tb_chain_shift_controller;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] data_in;
    logic [2:0] dv;
    logic       abort;
    wire  [2:0] ready_w, tx_w, en_w, upd_w, rv_w, busy_w;
    logic [2:0] rx_w;
    logic [7:0] rb_w [3];

    logic [7:0] sh_m  [3];
    logic [7:0] par_m [3];
    int         en_cnt  [3];
    int         upd_cnt [3];
    int         rv_cnt  [3];
    logic [2:0] pre_ld;
    logic [7:0] pre_val;
    logic       mon_on;
    logic [2:0] mon_prev;

    int n_checks = 0;
    int n_bad    = 0;

    always #5 clk = ~clk;

    chain_shift_controller #(.CHAIN_LENGTH(8), .MSB_FIRST(1), .SETTLE_CYCLES(1), .UPDATE_CYCLES(1)) dut_a (
        .clk(clk), .reset(reset), .data_in(data_in), .data_valid(dv[0]), .data_ready(ready_w[0]),
        .abort(abort), .chain_tx(tx_w[0]), .enable(en_w[0]), .update(upd_w[0]), .chain_rx(rx_w[0]),
        .readback(rb_w[0]), .readback_valid(rv_w[0]), .busy(busy_w[0]));

    chain_shift_controller #(.CHAIN_LENGTH(8), .MSB_FIRST(0), .SETTLE_CYCLES(1), .UPDATE_CYCLES(1)) dut_b (
        .clk(clk), .reset(reset), .data_in(data_in), .data_valid(dv[1]), .data_ready(ready_w[1]),
        .abort(abort), .chain_tx(tx_w[1]), .enable(en_w[1]), .update(upd_w[1]), .chain_rx(rx_w[1]),
        .readback(rb_w[1]), .readback_valid(rv_w[1]), .busy(busy_w[1]));

    chain_shift_controller #(.CHAIN_LENGTH(8), .MSB_FIRST(1), .SETTLE_CYCLES(0), .UPDATE_CYCLES(3)) dut_c (
        .clk(clk), .reset(reset), .data_in(data_in), .data_valid(dv[2]), .data_ready(ready_w[2]),
        .abort(abort), .chain_tx(tx_w[2]), .enable(en_w[2]), .update(upd_w[2]), .chain_rx(rx_w[2]),
        .readback(rb_w[2]), .readback_valid(rv_w[2]), .busy(busy_w[2]));

    // Cell chain model: shift on enabled rising edges, transfer on update
    always @(posedge clk) begin
        for (int g = 0; g < 3; g++) begin
            if (pre_ld[g]) sh_m[g] <= pre_val;
            else if (en_w[g]) sh_m[g] <= {sh_m[g][6:0], tx_w[g]};
            if (upd_w[g]) par_m[g] <= sh_m[g];
            if (en_w[g]) en_cnt[g] <= en_cnt[g] + 1;
            if (upd_w[g]) upd_cnt[g] <= upd_cnt[g] + 1;
            if (rv_w[g]) rv_cnt[g] <= rv_cnt[g] + 1;
        end
    end

    // Last cell launches its bit on the falling edge
    always @(negedge clk) begin
        for (int g = 0; g < 3; g++) rx_w[g] <= sh_m[g][7];
    end

    // Chain-facing outputs of instance 2 must not move at a rising edge
    always begin
        @(posedge clk);
        mon_prev = {tx_w[2], en_w[2], upd_w[2]};
        #1;
        if (mon_on) check_value("edge_only", 32'({tx_w[2], en_w[2], upd_w[2]}), 32'(mon_prev));
    end

    task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic preload(input int g, input logic [7:0] v);
        @(negedge clk);
        pre_val   = v;
        pre_ld[g] = 1'b1;
        @(negedge clk);
        pre_ld[g] = 1'b0;
    endtask

    // Full transfer; cycle 1 is the cycle that starts at the handshake edge
    task automatic run_xfer(input int g, input logic [7:0] d, input bit hold, input logic [7:0] nxt,
                            input logic [7:0] exp_rb, input logic [7:0] exp_par,
                            input int exp_lat, input int exp_upd);
        int tries, cyc, en0, upd0, rdy_seen;
        tries = 0;
        while (ready_w[g] !== 1'b1 && tries < 50) begin
            @(negedge clk);
            tries++;
        end
        check_value("ready_before", 32'(ready_w[g]), 32'd1);
        data_in = d;
        dv[g]   = 1'b1;
        en0     = en_cnt[g];
        upd0    = upd_cnt[g];
        @(posedge clk);
        #1;
        if (hold) data_in = nxt;
        else dv[g] = 1'b0;
        check_value("busy_after_accept", 32'(busy_w[g]), 32'd1);
        cyc = 1;
        rdy_seen = 0;
        while (rv_w[g] !== 1'b1 && cyc < 60) begin
            if (ready_w[g] !== 1'b0) rdy_seen++;
            @(posedge clk);
            #1;
            cyc++;
        end
        check_value("latency", 32'(cyc), 32'(exp_lat));
        check_value("readback", 32'(rb_w[g]), 32'(exp_rb));
        check_value("cell_outputs", 32'(par_m[g]), 32'(exp_par));
        check_value("enable_edges", 32'(en_cnt[g] - en0), 32'd8);
        check_value("update_edges", 32'(upd_cnt[g] - upd0), 32'(exp_upd));
        check_value("ready_held_off", 32'(rdy_seen), 32'd0);
    endtask

    initial begin
        int en0, upd0, rv0, t;
        reset   = 1'b1;
        data_in = 8'h00;
        dv      = 3'b000;
        abort   = 1'b0;
        pre_ld  = 3'b000;
        pre_val = 8'h00;
        mon_on  = 1'b0;
        @(negedge clk);
        pre_ld = 3'b111;
        @(negedge clk);
        pre_ld = 3'b000;
        check_value("ready_in_reset", 32'(ready_w), 32'd0);
        check_value("outs_in_reset", 32'({tx_w, en_w, upd_w, rv_w, busy_w}), 32'd0);
        check_value("rb_in_reset", 32'(rb_w[0]), 32'd0);
        reset = 1'b0;
        @(posedge clk);
        #1;
        check_value("ready_after_reset", 32'(ready_w), 32'd7);

        // Basic MSB-first transfer
        preload(0, 8'h3C);
        run_xfer(0, 8'hA5, 1'b0, 8'h00, 8'h3C, 8'hA5, 11, 1);

        // Back-to-back with data_valid held; second word waits for DONE
        run_xfer(0, 8'hA5, 1'b1, 8'h0F, 8'hA5, 8'hA5, 11, 1);
        @(negedge clk);
        check_value("held_off_in_done", 32'(ready_w[0]), 32'd0);
        @(negedge clk);
        check_value("ready_after_done", 32'(ready_w[0]), 32'd1);
        run_xfer(0, 8'h0F, 1'b0, 8'h00, 8'hA5, 8'h0F, 11, 1);

        // LSB-first: a lone bit 0 is sent on the first shift, lands in the last cell
        preload(1, 8'h06);
        run_xfer(1, 8'h01, 1'b0, 8'h00, 8'h60, 8'h80, 11, 1);
        run_xfer(1, 8'h00, 1'b0, 8'h00, 8'h01, 8'h00, 11, 1);

        // Abort sampled on the fourth shift edge
        t = 0;
        while (ready_w[0] !== 1'b1 && t < 50) begin
            @(negedge clk);
            t++;
        end
        data_in = 8'h00;
        dv[0]   = 1'b1;
        en0 = en_cnt[0];
        upd0 = upd_cnt[0];
        rv0 = rv_cnt[0];
        @(posedge clk);
        #1;
        dv[0] = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        abort = 1'b1;
        @(posedge clk);
        #1;
        abort = 1'b0;
        check_value("abort_busy", 32'(busy_w[0]), 32'd0);
        check_value("abort_ready", 32'(ready_w[0]), 32'd1);
        check_value("abort_en_until_fall", 32'(en_w[0]), 32'd1);
        @(negedge clk);
        #1;
        check_value("abort_en_fall", 32'(en_w[0]), 32'd0);
        repeat (16) @(posedge clk);
        #1;
        check_value("abort_shifts", 32'(en_cnt[0] - en0), 32'd4);
        check_value("abort_no_update", 32'(upd_cnt[0] - upd0), 32'd0);
        check_value("abort_no_valid", 32'(rv_cnt[0] - rv0), 32'd0);
        check_value("abort_rb_kept", 32'(rb_w[0]), 32'hA5);
        check_value("abort_partial", 32'(sh_m[0]), 32'hF0);
        check_value("abort_par_kept", 32'(par_m[0]), 32'h0F);

        // Reset in the middle of SHIFT
        data_in = 8'hFF;
        dv[0]   = 1'b1;
        @(posedge clk);
        #1;
        dv[0] = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        #2;
        check_value("pre_reset_en", 32'(en_w[0]), 32'd1);
        reset = 1'b1;
        #1;
        check_value("reset_async_shift", 32'({tx_w[0], en_w[0], upd_w[0], rv_w[0], busy_w[0], ready_w[0]}), 32'd0);
        check_value("reset_rb", 32'(rb_w[0]), 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        check_value("ready_after_release", 32'(ready_w[0]), 32'd1);

        // Reset in the middle of UPDATE
        data_in = 8'h55;
        dv[2]   = 1'b1;
        @(posedge clk);
        #1;
        dv[2] = 1'b0;
        t = 0;
        while (upd_w[2] !== 1'b1 && t < 40) begin
            @(negedge clk);
            #1;
            t++;
        end
        check_value("pre_reset_upd", 32'(upd_w[2]), 32'd1);
        reset = 1'b1;
        upd0 = upd_cnt[2];
        #1;
        check_value("reset_async_update", 32'({tx_w[2], en_w[2], upd_w[2], rv_w[2], busy_w[2], ready_w[2]}), 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check_value("no_update_after_reset", 32'(upd_cnt[2] - upd0), 32'd0);
        check_value("no_valid_after_reset", 32'(rv_w[2]), 32'd0);

        // Fresh transfer after reset
        preload(0, 8'h5A);
        run_xfer(0, 8'hC3, 1'b0, 8'h00, 8'h5A, 8'hC3, 11, 1);

        // No settle, 3-cycle update, launch edges watched
        preload(2, 8'h81);
        mon_on = 1'b1;
        run_xfer(2, 8'h7E, 1'b0, 8'h00, 8'h81, 8'h7E, 12, 3);
        repeat (2) @(posedge clk);
        #2;
        mon_on = 1'b0;

        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

endmodule
